// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter driving a registered register-file write port.
// Define REGARB_SCOREBOARD_EN to build the per-register pending-write scoreboard on busy.
module regfile_write_arbiter #(
  parameter int unsigned RR_EN = 1
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        req_valid_a,
  input  logic [4:0]  req_reg_a,
  input  logic [31:0] req_data_a,
  input  logic        req_valid_b,
  input  logic [4:0]  req_reg_b,
  input  logic [31:0] req_data_b,
  output logic        req_ready_a,
  output logic        req_ready_b,
  input  logic        hold,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  output logic [31:0] busy
);

  localparam bit RrOn = (RR_EN != 0);

  logic        w_allow;
  logic        w_pref_b;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_accept;
  logic [4:0]  w_reg;
  logic [31:0] w_data;

  // r_last_a is 1 when A holds the most recent grant; reset leaves B as last winner.
  logic        r_last_a;
  logic        r_we;
  logic [4:0]  r_wreg;
  logic [31:0] r_wdata;

  always_comb begin
    w_allow   = !ctrl_reset && !hold;
    w_pref_b  = RrOn && r_last_a;
    w_grant_a = w_allow && req_valid_a && !(req_valid_b && w_pref_b);
    w_grant_b = w_allow && req_valid_b && !(req_valid_a && !w_pref_b);
    w_accept  = w_grant_a || w_grant_b;
    w_reg     = w_grant_a ? req_reg_a : req_reg_b;
    w_data    = w_grant_a ? req_data_a : req_data_b;
  end

  assign req_ready_a = w_grant_a;
  assign req_ready_b = w_grant_b;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_we     <= 1'b0;
      r_wreg   <= 5'd0;
      r_wdata  <= 32'd0;
      r_last_a <= 1'b0;
    end else begin
      // Writes to x0 are consumed but never reach the register file.
      r_we <= w_accept && (w_reg != 5'd0);
      if (w_accept) begin
        r_wreg   <= w_reg;
        r_wdata  <= w_data;
        r_last_a <= w_grant_a;
      end
    end
  end

  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_wreg;
  assign data_writeReg    = r_wdata;

`ifdef REGARB_SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_busy_set;
  logic [31:0] w_busy_clr;
  logic [31:0] w_busy_d;

  // A new issue wins over a retiring write to the same register.
  always_comb begin
    w_busy_set  = issue_valid ? (32'd1 << issue_reg) : 32'd0;
    w_busy_clr  = r_we ? (32'd1 << r_wreg) : 32'd0;
    w_busy_d    = (r_busy & ~w_busy_clr) | w_busy_set;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  assign busy = r_busy;
`else
  logic w_unused_issue;
  assign w_unused_issue = ^{issue_valid, issue_reg};
  assign busy = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench: a round-robin and a fixed-priority instance share stimulus
// and are both compared against a per-instance behavioural model.
module tb_regfile_write_arbiter;

`ifdef REGARB_SCOREBOARD_EN
  localparam bit ScbOn = 1'b1;
`else
  localparam bit ScbOn = 1'b0;
`endif

  logic        clock;
  logic        ctrl_reset;
  logic        req_valid_a, req_valid_b;
  logic [4:0]  req_reg_a, req_reg_b;
  logic [31:0] req_data_a, req_data_b;
  logic        hold;
  logic        issue_valid;
  logic [4:0]  issue_reg;

  logic [1:0]       ready_a, ready_b, we;
  logic [1:0][4:0]  wreg;
  logic [1:0][31:0] wdata, busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state, index 0 = round-robin, 1 = fixed priority.
  bit          rr_mode [2] = '{1'b1, 1'b0};
  bit          m_last_a [2];
  bit          m_we [2];
  logic [4:0]  m_reg [2];
  logic [31:0] m_data [2];
  bit          m_pend [2][32];

  regfile_write_arbiter #(.RR_EN(1)) u_rr (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .req_valid_a(req_valid_a), .req_reg_a(req_reg_a), .req_data_a(req_data_a),
    .req_valid_b(req_valid_b), .req_reg_b(req_reg_b), .req_data_b(req_data_b),
    .req_ready_a(ready_a[0]), .req_ready_b(ready_b[0]), .hold(hold),
    .ctrl_writeEnable(we[0]), .ctrl_writeReg(wreg[0]), .data_writeReg(wdata[0]),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .busy(busy[0])
  );

  regfile_write_arbiter #(.RR_EN(0)) u_fp (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .req_valid_a(req_valid_a), .req_reg_a(req_reg_a), .req_data_a(req_data_a),
    .req_valid_b(req_valid_b), .req_reg_b(req_reg_b), .req_data_b(req_data_b),
    .req_ready_a(ready_a[1]), .req_ready_b(ready_b[1]), .hold(hold),
    .ctrl_writeEnable(we[1]), .ctrl_writeReg(wreg[1]), .data_writeReg(wdata[1]),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .busy(busy[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last_a[k] = 1'b0;
      m_we[k]     = 1'b0;
      m_reg[k]    = 5'd0;
      m_data[k]   = 32'd0;
      for (int r = 0; r < 32; r++) m_pend[k][r] = 1'b0;
    end
  endtask

  // Compare both instances against the model, advance the model, then move to next negedge.
  task automatic tick();
    bit          ra, rb;
    logic [31:0] exp_busy;
    bit          nxt [32];
    #1;
    for (int k = 0; k < 2; k++) begin
      ra = 1'b0;
      rb = 1'b0;
      if (!ctrl_reset && !hold) begin
        if (req_valid_a && req_valid_b) begin
          if (rr_mode[k] && m_last_a[k]) rb = 1'b1;
          else ra = 1'b1;
        end else begin
          ra = req_valid_a;
          rb = req_valid_b;
        end
      end
      exp_busy = 32'd0;
      for (int r = 0; r < 32; r++) exp_busy[r] = m_pend[k][r];
      check_eq($sformatf("ready_a[%0d]", k), ready_a[k], ra);
      check_eq($sformatf("ready_b[%0d]", k), ready_b[k], rb);
      check_eq($sformatf("we[%0d]", k), we[k], m_we[k]);
      check_eq($sformatf("wreg[%0d]", k), wreg[k], m_reg[k]);
      check_eq($sformatf("wdata[%0d]", k), wdata[k], m_data[k]);
      check_eq($sformatf("busy[%0d]", k), busy[k], exp_busy);

      if (ctrl_reset) begin
        m_last_a[k] = 1'b0;
        m_we[k]     = 1'b0;
        m_reg[k]    = 5'd0;
        m_data[k]   = 32'd0;
        for (int r = 0; r < 32; r++) m_pend[k][r] = 1'b0;
      end else begin
        for (int r = 0; r < 32; r++) begin
          nxt[r] = m_pend[k][r];
          if (m_we[k] && m_reg[k] == 5'(r)) nxt[r] = 1'b0;
          if (issue_valid && issue_reg == 5'(r)) nxt[r] = 1'b1;
          if (r == 0 || !ScbOn) nxt[r] = 1'b0;
        end
        for (int r = 0; r < 32; r++) m_pend[k][r] = nxt[r];
        if (ra || rb) begin
          m_reg[k]    = ra ? req_reg_a : req_reg_b;
          m_data[k]   = ra ? req_data_a : req_data_b;
          m_we[k]     = (m_reg[k] != 5'd0);
          m_last_a[k] = ra;
        end else begin
          m_we[k] = 1'b0;
        end
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    ctrl_reset  = 1'b1;
    hold        = 1'b0;
    req_valid_a = 1'b1;
    req_reg_a   = 5'd3;
    req_data_a  = 32'h0BAD_0003;
    req_valid_b = 1'b0;
    req_reg_b   = 5'd0;
    req_data_b  = 32'd0;
    issue_valid = 1'b1;
    issue_reg   = 5'd9;
    repeat (2) @(posedge clock);
    @(negedge clock);
    model_reset();

    // Reset held with a pending request and an issue: nothing accepted or recorded.
    tick();
    check_eq("rst_we", we[0], 1'b0);
    check_eq("rst_busy", busy[0], 32'd0);
    ctrl_reset  = 1'b0;
    req_valid_a = 1'b0;
    issue_valid = 1'b0;
    tick();
    check_eq("rst_no_write", we[0], 1'b0);

    // Single A request.
    req_valid_a = 1'b1;
    req_reg_a   = 5'd5;
    req_data_a  = 32'hDEAD_BEEF;
    #1;
    check_eq("a_alone_ready", ready_a[0], 1'b1);
    tick();
    req_valid_a = 1'b0;
    #1;
    check_eq("a_alone_we", we[0], 1'b1);
    check_eq("a_alone_reg", wreg[0], 5'd5);
    check_eq("a_alone_data", wdata[0], 32'hDEAD_BEEF);

    // B writes x0: consumed, no write enable.
    req_valid_b = 1'b1;
    req_reg_b   = 5'd0;
    req_data_b  = 32'h0000_1234;
    #1;
    check_eq("b_x0_ready", ready_b[0], 1'b1);
    tick();
    req_valid_b = 1'b0;
    #1;
    check_eq("b_x0_we", we[0], 1'b0);

    // Four-cycle contention; last grant was B so round-robin starts with A.
    req_valid_a = 1'b1;
    req_valid_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_reg_a  = 5'(1 + i);
      req_data_a = 32'hA000_0000 + 32'(i);
      req_reg_b  = 5'(10 + i);
      req_data_b = 32'hB000_0000 + 32'(i);
      #1;
      check_eq($sformatf("rr_ready_a_%0d", i), ready_a[0], (i % 2) == 0);
      check_eq($sformatf("rr_ready_b_%0d", i), ready_b[0], (i % 2) == 1);
      check_eq($sformatf("fp_ready_a_%0d", i), ready_a[1], 1'b1);
      check_eq($sformatf("fp_ready_b_%0d", i), ready_b[1], 1'b0);
      tick();
      check_eq($sformatf("rr_we_%0d", i), we[0], 1'b1);
      check_eq($sformatf("rr_data_%0d", i), wdata[0],
               ((i % 2) == 0) ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i));
    end
    req_valid_a = 1'b0;
    #1;
    check_eq("fp_b_after_a_drop", ready_b[1], 1'b1);
    tick();
    req_valid_b = 1'b0;

    // Hold with both valid, then release.
    req_valid_a = 1'b1;
    req_valid_b = 1'b1;
    hold        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("hold_ready_a_%0d", i), ready_a[0], 1'b0);
      check_eq($sformatf("hold_ready_b_%0d", i), ready_b[0], 1'b0);
      tick();
      check_eq($sformatf("hold_we_%0d", i), we[0], 1'b0);
    end
    hold = 1'b0;
    #1;
    check_eq("unhold_rr_a", ready_a[0], 1'b1);
    check_eq("unhold_rr_b", ready_b[0], 1'b0);
    check_eq("unhold_fp_a", ready_a[1], 1'b1);
    tick();
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    tick();

`ifdef REGARB_SCOREBOARD_EN
    issue_valid = 1'b1;
    issue_reg   = 5'd7;
    tick();
    issue_valid = 1'b0;
    #1;
    check_eq("scb_set", busy[0][7], 1'b1);
    req_valid_a = 1'b1;
    req_reg_a   = 5'd7;
    req_data_a  = 32'h0000_0077;
    tick();
    req_valid_a = 1'b0;
    issue_valid = 1'b1;
    issue_reg   = 5'd7;
    #1;
    check_eq("scb_we_cycle_we", we[0], 1'b1);
    check_eq("scb_we_cycle_busy", busy[0][7], 1'b1);
    tick();
    issue_valid = 1'b0;
    #1;
    check_eq("scb_reissue_kept", busy[0][7], 1'b1);
    req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    tick();
    #1;
    check_eq("scb_cleared", busy[0][7], 1'b0);
`else
    issue_valid = 1'b1;
    issue_reg   = 5'd7;
    tick();
    issue_valid = 1'b0;
    #1;
    check_eq("no_scb_busy", busy[0], 32'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      ctrl_reset  = ($urandom_range(0, 49) == 0);
      hold        = ($urandom_range(0, 9) == 0);
      req_valid_a = 1'($urandom_range(0, 1));
      req_valid_b = 1'($urandom_range(0, 1));
      req_reg_a   = 5'($urandom_range(0, 31));
      req_reg_b   = 5'($urandom_range(0, 31));
      req_data_a  = $urandom;
      req_data_b  = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_reg   = 5'($urandom_range(0, 31));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
